// File: rtl/apb_req_bridge.sv
// Single-outstanding request-to-APB master bridge: IDLE -> SETUP -> ACCESS, one-cycle response strobe.
// Optional ACCESS-phase timeout is enabled by defining the macro APB_TIMEOUT_EN.
module apb_req_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                    state_q, state_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          pwrite_d = we_i;
          paddr_d  = addr_i;
          pwdata_d = wdata_i;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        // Completion is registered so the response strobe lands in the following IDLE cycle.
        if (pready_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : prdata_i;
          err_d    = pslverr_i;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign pwrite_o = pwrite_q;
  assign paddr_o  = paddr_q;
  assign pwdata_o = pwdata_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: each transfer is described by its fields and wait count,
// and the expected APB phase timeline and response are derived from those fields.
module tb_apb_req_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o, psel_o, penable_o, pwrite_o;
  logic [31:0] rdata_o, paddr_o, pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // Last completed/issued transfer, used for the hold checks in idle cycles.
  logic [31:0] last_addr = '0, last_wdata = '0, last_rdata = '0;
  logic        last_we = 1'b0, last_err = 1'b0;

  apb_req_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic randomize_noise();
    pready_i  = 1'($urandom);
    pslverr_i = 1'($urandom);
    prdata_i  = $urandom;
  endtask

  // Issues one transfer starting in an IDLE cycle; returns in the response cycle with req_i low.
  task automatic run_xfer(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits, input logic [31:0] rd,
                          input logic slverr);
    logic [31:0] exp_rdata;
    exp_rdata = we ? 32'h0 : rd;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    randomize_noise();
    #1;
    checks++;
    if (gnt_o !== 1'b1 || psel_o !== 1'b0 || penable_o !== 1'b0) begin
      errors++;
      $display("FAIL %s grant: gnt=%b psel=%b penable=%b required 1 0 0", name, gnt_o, psel_o, penable_o);
    end
    next_cycle();
    req_i = 1'($urandom); we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
    randomize_noise();
    #1;
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b0 || gnt_o !== 1'b0 || rvalid_o !== 1'b0 ||
        paddr_o !== addr || pwrite_o !== we || pwdata_o !== wdata) begin
      errors++;
      $display("FAIL %s setup: psel=%b penable=%b gnt=%b rvalid=%b paddr=%h pwrite=%b pwdata=%h required 1 0 0 0 %h %b %h",
               name, psel_o, penable_o, gnt_o, rvalid_o, paddr_o, pwrite_o, pwdata_o, addr, we, wdata);
    end
    for (int w = 0; w <= waits; w++) begin
      next_cycle();
      req_i     = 1'($urandom);
      addr_i    = $urandom;
      pready_i  = (w == waits);
      prdata_i  = (w == waits) ? rd : $urandom;
      pslverr_i = (w == waits) ? slverr : 1'($urandom);
      #1;
      checks++;
      if (psel_o !== 1'b1 || penable_o !== 1'b1 || gnt_o !== 1'b0 || rvalid_o !== 1'b0 ||
          paddr_o !== addr || pwrite_o !== we || pwdata_o !== wdata) begin
        errors++;
        $display("FAIL %s access[%0d]: psel=%b penable=%b gnt=%b rvalid=%b paddr=%h pwrite=%b pwdata=%h required 1 1 0 0 %h %b %h",
                 name, w, psel_o, penable_o, gnt_o, rvalid_o, paddr_o, pwrite_o, pwdata_o, addr, we, wdata);
      end
    end
    next_cycle();
    req_i = 1'b0;
    randomize_noise();
    #1;
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== exp_rdata || err_o !== slverr || psel_o !== 1'b0 ||
        penable_o !== 1'b0) begin
      errors++;
      $display("FAIL %s response: rvalid=%b rdata=%h err=%b psel=%b penable=%b required 1 %h %b 0 0",
               name, rvalid_o, rdata_o, err_o, psel_o, penable_o, exp_rdata, slverr);
    end
    last_addr = addr; last_we = we; last_wdata = wdata; last_rdata = exp_rdata; last_err = slverr;
  endtask

  task automatic idle_cycle(input string name);
    next_cycle();
    req_i = 1'b0; addr_i = $urandom; we_i = 1'($urandom); wdata_i = $urandom;
    randomize_noise();
    #1;
    checks++;
    if (rvalid_o !== 1'b0 || rdata_o !== last_rdata || err_o !== last_err || psel_o !== 1'b0 ||
        penable_o !== 1'b0 || gnt_o !== 1'b0 || paddr_o !== last_addr || pwrite_o !== last_we ||
        pwdata_o !== last_wdata) begin
      errors++;
      $display("FAIL %s idle hold: rvalid=%b rdata=%h err=%b psel=%b paddr=%h pwrite=%b pwdata=%h required 0 %h %b 0 %h %b %h",
               name, rvalid_o, rdata_o, err_o, psel_o, paddr_o, pwrite_o, pwdata_o,
               last_rdata, last_err, last_addr, last_we, last_wdata);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
      randomize_noise();
      #1;
      checks++;
      if (psel_o !== 1'b0 || penable_o !== 1'b0 || pwrite_o !== 1'b0 || rvalid_o !== 1'b0 ||
          err_o !== 1'b0 || paddr_o !== 32'h0 || pwdata_o !== 32'h0 || rdata_o !== 32'h0) begin
        errors++;
        $display("FAIL reset values: psel=%b penable=%b pwrite=%b rvalid=%b err=%b paddr=%h pwdata=%h rdata=%h required all zero",
                 psel_o, penable_o, pwrite_o, rvalid_o, err_o, paddr_o, pwdata_o, rdata_o);
      end
    end
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_write_single();
    run_xfer("write_single", 1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0);
    idle_cycle("write_single");
  endtask

  task automatic test_read_wait();
    run_xfer("read_wait", 1'b0, 32'h1A10_2000, 32'h0BAD_F00D, 4, 32'h1234_5678, 1'b0);
    idle_cycle("read_wait");
  endtask

  task automatic test_slverr();
    run_xfer("read_slverr", 1'b0, 32'h1A10_3008, 32'h0, 2, 32'hCAFE_0001, 1'b1);
    idle_cycle("read_slverr");
    idle_cycle("read_slverr");
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_0", 1'b1, 32'h0000_0100, 32'h1111_1111, 0, 32'h0, 1'b0);
    run_xfer("b2b_1", 1'b0, 32'h0000_0104, 32'h2222_2222, 0, 32'h3333_3333, 1'b0);
    run_xfer("b2b_2", 1'b1, 32'h0000_0108, 32'h4444_4444, 0, 32'h5555_5555, 1'b0);
    idle_cycle("b2b");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      run_xfer($sformatf("rand_%0d", t), 1'($urandom), $urandom, $urandom,
               int'($urandom_range(5, 0)), $urandom, 1'($urandom));
      if ($urandom_range(1, 0) == 1) idle_cycle($sformatf("rand_%0d", t));
    end
    idle_cycle("rand_end");
  endtask

  task automatic test_reset_abort();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h5000_0010; wdata_i = 32'h0;
    next_cycle();
    req_i = 1'b0; pready_i = 1'b0;
    next_cycle();
    pready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || rvalid_o !== 1'b0 || paddr_o !== 32'h0 ||
        rdata_o !== 32'h0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL abort immediate: psel=%b penable=%b rvalid=%b paddr=%h rdata=%h err=%b required all zero",
               psel_o, penable_o, rvalid_o, paddr_o, rdata_o, err_o);
    end
    next_cycle();
    rst_ni = 1'b1;
    pready_i = 1'b1; prdata_i = 32'hFFFF_FFFF;
    last_addr = '0; last_we = 1'b0; last_wdata = '0; last_rdata = '0; last_err = 1'b0;
    for (int i = 0; i < 4; i++) idle_cycle($sformatf("abort_after_%0d", i));
    next_cycle();
    run_xfer("after_abort", 1'b0, 32'h5000_0014, 32'h0, 1, 32'h0A0B_0C0D, 1'b0);
    idle_cycle("after_abort");
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    // pready on the 8th ACCESS cycle still completes normally.
    run_xfer("limit_ready", 1'b0, 32'h6000_0000, 32'h0, 7, 32'h7777_0007, 1'b0);
    idle_cycle("limit_ready");
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h6000_0004;
    next_cycle();
    req_i = 1'b0; pready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      pready_i = 1'b0; pslverr_i = 1'($urandom); prdata_i = $urandom;
      #1;
      checks++;
      if (psel_o !== 1'b1 || penable_o !== 1'b1 || rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout access[%0d]: psel=%b penable=%b rvalid=%b required 1 1 0",
                 i, psel_o, penable_o, rvalid_o);
      end
    end
    next_cycle();
    pready_i = 1'b1; prdata_i = $urandom;
    #1;
    checks++;
    if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0 || psel_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout response: rvalid=%b err=%b rdata=%h psel=%b required 1 1 00000000 0",
               rvalid_o, err_o, rdata_o, psel_o);
    end
    last_addr = 32'h6000_0004; last_we = 1'b0; last_rdata = 32'h0; last_err = 1'b1;
    idle_cycle("timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_write_single();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_random();
    test_reset_abort();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
APB_REQ_BRIDGE -- requirements
Module: apb_req_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, address width of request and APB sides.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, data width of request and APB sides.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, ACCESS-phase cycle limit; used only when APB_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port req_i, input, 1, request valid.
REQ-007 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port addr_i, input, APB_ADDR_WIDTH, request address.
REQ-009 SHALL have port wdata_i, input, APB_DATA_WIDTH, write data.
REQ-010 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-011 SHALL have port rvalid_o, output, 1, one-cycle response strobe.
REQ-012 SHALL have port rdata_o, output, APB_DATA_WIDTH, read data, valid with rvalid_o.
REQ-013 SHALL have port err_o, output, 1, error flag, valid with rvalid_o.
REQ-014 SHALL have ports psel_o, penable_o, pwrite_o (outputs, 1), paddr_o (output, APB_ADDR_WIDTH) and pwdata_o (output, APB_DATA_WIDTH), APB master request to the downstream node.
REQ-015 SHALL have ports prdata_i (input, APB_DATA_WIDTH), pready_i (input, 1) and pslverr_i (input, 1), APB completion from the downstream node.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-017 In IDLE, gnt_o SHALL equal req_i combinationally; gnt_o SHALL be 0 in SETUP and ACCESS.
REQ-018 On req_i=1 in IDLE, SHALL register we_i, addr_i and wdata_i, and go to SETUP next cycle.
REQ-019 In SETUP: psel_o=1, penable_o=0, unconditional transition to ACCESS.
REQ-020 In ACCESS: psel_o=1, penable_o=1; SHALL stay in ACCESS while pready_i=0.
REQ-021 On pready_i=1 in ACCESS, SHALL go to IDLE and, next cycle, drive rvalid_o=1 for exactly one cycle.
REQ-022 With that rvalid_o pulse: rdata_o=prdata_i if the transfer was a read, 0 if a write; err_o=pslverr_i.
REQ-023 paddr_o, pwrite_o and pwdata_o SHALL come from the captured registers and stay stable throughout SETUP and ACCESS.
REQ-024 In IDLE: psel_o=0, penable_o=0; paddr_o, pwrite_o and pwdata_o hold their last values.
REQ-025 rdata_o and err_o SHALL hold until the next response.
REQ-026 A request in the same cycle as rvalid_o SHALL be granted (back-to-back); minimum 3 cycles per transfer.
REQ-027 SHALL ignore pready_i and pslverr_i outside ACCESS.

Reset
REQ-028 While rst_ni=0: state=IDLE; psel_o, penable_o, pwrite_o, rvalid_o, err_o = 0; paddr_o, pwdata_o, rdata_o = 0.
REQ-029 Reset during SETUP or ACCESS SHALL abort the transfer with no rvalid_o after release.
REQ-030 The first grant after reset release SHALL be possible in the first cycle with rst_ni=1.

Configuration
REQ-031 Macro APB_TIMEOUT_EN defined: an ACCESS-cycle counter, cleared on SETUP->ACCESS, SHALL increment each ACCESS cycle with pready_i=0.
REQ-032 With APB_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES-1 with pready_i=0: go to IDLE, rvalid_o=1 next cycle, err_o=1, rdata_o=0.
REQ-033 With APB_TIMEOUT_EN, pready_i=1 on the limit cycle SHALL win (normal completion).
REQ-034 APB_TIMEOUT_EN undefined: no counter logic; ACCESS waits indefinitely for pready_i.

Verification
REQ-035 Write addr=0x1A10_0004, wdata=0xDEAD_BEEF, pready_i=1 first ACCESS cycle -> gnt cycle 0, SETUP cycle 1, ACCESS cycle 2, rvalid_o cycle 3, rdata_o=0, err_o=0.
REQ-036 Read addr=0x1A10_2000, pready_i low for 4 ACCESS cycles, then prdata_i=0x1234_5678 -> rvalid_o once, rdata_o=0x1234_5678, APB address stable for all 6 phase cycles.
REQ-037 Read with pslverr_i=1 at completion -> err_o=1, rvalid_o one cycle.
REQ-038 req_i held high for 3 transfers with pready_i=1 -> grants every 3 cycles, 3 rvalid_o pulses.
REQ-039 rst_ni low in ACCESS -> psel_o=0 and penable_o=0 immediately, no rvalid_o after release.
REQ-040 APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready_i stuck 0 -> rvalid_o after 8 ACCESS cycles, err_o=1, rdata_o=0.
